// File: rtl/ysyx_22050243_decode_stage.sv
// Decode-control stage between IFU and EXU: one-entry pipeline register,
// valid/ready backpressure, flush, trap detection and RUN/HALT control.
module ysyx_22050243_decode_stage #(
  parameter int XLEN       = 64,
  parameter bit RV64       = 1'b1,
  parameter bit ENABLE_CSR = 1'b1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [XLEN-1:0]  out_pc,
  output logic             alu_src,
  output logic             reg_w,
  output logic             mem_r,
  output logic             mem_w,
  output logic             branch,
  output logic             csr_r,
  output logic [2:0]       mem2reg,
  output logic [1:0]       pc_src_ctrl,
  output logic [2:0]       alu_op,
  output logic             exc_illegal,
  output logic             exc_ecall,
  output logic             exc_ebreak,
  output logic             halted,
  output logic             halt_code,
  output logic [CNT_W-1:0] decode_cnt
);

  typedef enum logic {RUN, HALT} state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_32     = 7'b0111011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t      state;
  state_t      state_nxt;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [13:0] dvec;
  logic [13:0] vec_q;
  logic        d_ill;
  logic        d_ecall;
  logic        d_ebreak;
  logic        in_fire;
  logic        out_fire;

  assign opc = in_inst[6:0];
  assign f3  = in_inst[14:12];

  // dvec = {csr_r, alu_src, mem2reg, reg_w, mem_r, mem_w, branch, pc_src, alu_op}
  always_comb begin
    dvec     = '0;
    d_ill    = 1'b0;
    d_ecall  = 1'b0;
    d_ebreak = 1'b0;
    unique case (1'b1)
      (in_inst == 32'h0): ;
      (opc == OP_LUI):    dvec = 14'b0_0_010_1_0_0_0_00_000;
      (opc == OP_AUIPC):  dvec = 14'b0_0_100_1_0_0_0_00_000;
      (opc == OP_JAL):    dvec = 14'b0_0_011_1_0_0_0_01_000;
      (opc == OP_JALR):   dvec = 14'b0_0_011_1_0_0_0_10_000;
      (opc == OP_BRANCH): dvec = 14'b0_0_000_0_0_0_1_00_001;
      (opc == OP_LOAD):   dvec = 14'b0_1_001_1_1_0_0_00_000;
      (opc == OP_STORE):  dvec = 14'b0_1_000_0_0_1_0_00_000;
      (opc == OP_IMM):    dvec = 14'b0_1_000_1_0_0_0_00_011;
      (opc == OP_OP):     dvec = 14'b0_0_000_1_0_0_0_00_010;
      (opc == OP_FENCE):  dvec = '0;
      (opc == OP_IMM32): begin
        if (RV64) dvec = 14'b0_1_000_1_0_0_0_00_111;
        else      d_ill = 1'b1;
      end
      (opc == OP_32): begin
        if (RV64) dvec = 14'b0_0_000_1_0_0_0_00_110;
        else      d_ill = 1'b1;
      end
      (opc == OP_SYSTEM && f3 == 3'b000): begin
        if (in_inst[31:20] == 12'h000)      d_ecall  = 1'b1;
        else if (in_inst[31:20] == 12'h001) d_ebreak = 1'b1;
        else                                d_ill    = 1'b1;
      end
      // funct3 100 has low bits 00 and falls to the illegal default
      (opc == OP_SYSTEM && f3[1:0] != 2'b00): begin
        if (ENABLE_CSR) dvec = 14'b1_0_101_1_0_0_0_00_000;
        else            d_ill = 1'b1;
      end
      default: d_ill = 1'b1;
    endcase
  end

  assign in_ready = (state == RUN) & ~flush & (~out_valid | out_ready);
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign halted   = (state == HALT);

  assign {csr_r, alu_src, mem2reg, reg_w, mem_r,
          mem_w, branch, pc_src_ctrl, alu_op} = vec_q;

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN: begin
        if (out_fire && !flush && (exc_ebreak || exc_illegal))
          state_nxt = HALT;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      out_valid   <= 1'b0;
      vec_q       <= '0;
      exc_illegal <= 1'b0;
      exc_ecall   <= 1'b0;
      exc_ebreak  <= 1'b0;
      out_inst    <= '0;
      out_pc      <= '0;
      halt_code   <= 1'b0;
      decode_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (state == RUN && state_nxt == HALT)
        halt_code <= exc_illegal;
      if (out_fire && !flush)
        decode_cnt <= decode_cnt + CNT_ONE;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (in_fire) begin
        out_valid   <= 1'b1;
        vec_q       <= dvec;
        exc_illegal <= d_ill;
        exc_ecall   <= d_ecall;
        exc_ebreak  <= d_ebreak;
        out_inst    <= in_inst;
        out_pc      <= in_pc;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050243_decode_stage.sv
// Bench for the decode stage: a default instance and an RV32/no-CSR/4-bit
// counter instance share stimulus and are checked against a queue-level model.
module tb_ysyx_22050243_decode_stage;

  logic        clk = 1'b0;
  logic        rst, rst2, in_valid, flush, out_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;

  logic        rdy_a, ov_a, src_a, regw_a, mr_a, mw_a, br_a, csr_a;
  logic        ill_a, ec_a, eb_a, hlt_a, hc_a;
  logic [2:0]  m2r_a, aop_a;
  logic [1:0]  pcs_a;
  logic [31:0] oi_a, cnt_a;
  logic [63:0] op_a;

  logic        rdy_b, ov_b, src_b, regw_b, mr_b, mw_b, br_b, csr_b;
  logic        ill_b, ec_b, eb_b, hlt_b, hc_b;
  logic [2:0]  m2r_b, aop_b;
  logic [1:0]  pcs_b;
  logic [31:0] oi_b;
  logic [3:0]  cnt_b;
  logic [63:0] op_b;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  ysyx_22050243_decode_stage #(
    .XLEN(64), .RV64(1'b1), .ENABLE_CSR(1'b1), .CNT_W(32)
  ) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
    .out_valid(ov_a), .out_ready(out_ready),
    .out_inst(oi_a), .out_pc(op_a),
    .alu_src(src_a), .reg_w(regw_a), .mem_r(mr_a), .mem_w(mw_a),
    .branch(br_a), .csr_r(csr_a), .mem2reg(m2r_a),
    .pc_src_ctrl(pcs_a), .alu_op(aop_a),
    .exc_illegal(ill_a), .exc_ecall(ec_a), .exc_ebreak(eb_a),
    .halted(hlt_a), .halt_code(hc_a), .decode_cnt(cnt_a)
  );

  ysyx_22050243_decode_stage #(
    .XLEN(64), .RV64(1'b0), .ENABLE_CSR(1'b0), .CNT_W(4)
  ) dut_b (
    .clk(clk), .rst(rst2), .in_valid(in_valid), .in_ready(rdy_b),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
    .out_valid(ov_b), .out_ready(out_ready),
    .out_inst(oi_b), .out_pc(op_b),
    .alu_src(src_b), .reg_w(regw_b), .mem_r(mr_b), .mem_w(mw_b),
    .branch(br_b), .csr_r(csr_b), .mem2reg(m2r_b),
    .pc_src_ctrl(pcs_b), .alu_op(aop_b),
    .exc_illegal(ill_b), .exc_ecall(ec_b), .exc_ebreak(eb_b),
    .halted(hlt_b), .halt_code(hc_b), .decode_cnt(cnt_b)
  );

  // Opcode table: control vector per instruction class, and whether the
  // class only exists on RV64.
  logic [6:0]  t_op [12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                             7'h23, 7'h13, 7'h33, 7'h1B, 7'h3B, 7'h0F};
  logic [13:0] t_v  [12] = '{14'b0_0_010_1_0_0_0_00_000,
                             14'b0_0_100_1_0_0_0_00_000,
                             14'b0_0_011_1_0_0_0_01_000,
                             14'b0_0_011_1_0_0_0_10_000,
                             14'b0_0_000_0_0_0_1_00_001,
                             14'b0_1_001_1_1_0_0_00_000,
                             14'b0_1_000_0_0_1_0_00_000,
                             14'b0_1_000_1_0_0_0_00_011,
                             14'b0_0_000_1_0_0_0_00_010,
                             14'b0_1_000_1_0_0_0_00_111,
                             14'b0_0_000_1_0_0_0_00_110,
                             14'b0};
  bit          t_64 [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0};

  localparam logic [13:0] CSR_V = 14'b1_0_101_1_0_0_0_00_000;

  logic [31:0] pool [17] = '{32'h00100093, 32'h0000B103, 32'h0020B023,
                             32'h008000EF, 32'h000012B7, 32'h00001297,
                             32'h00208463, 32'h000080E7, 32'h002081B3,
                             32'h002081BB, 32'h0010809B, 32'h30571073,
                             32'h300022F3, 32'h0000000F, 32'h00000073,
                             32'h00000000, 32'h00004073};

  // Model state per instance: held entry, count, halt status.
  bit          m_v [2];
  bit          m_h [2];
  bit          m_c [2];
  logic [16:0] m_d [2];
  logic [31:0] m_i [2];
  logic [63:0] m_p [2];
  int unsigned m_n [2];

  // Result layout: {vector[13:0], illegal, ecall, ebreak}
  function automatic logic [16:0] ref_dec(input logic [31:0] w,
                                          input bit rv64, input bit csr);
    logic [2:0] f3;
    f3 = w[14:12];
    if (w == 32'h0) return 17'd0;
    for (int i = 0; i < 12; i++)
      if (w[6:0] == t_op[i])
        return (t_64[i] && !rv64) ? 17'd4 : {t_v[i], 3'b000};
    if (w[6:0] == 7'h73) begin
      if (f3 == 3'd0) begin
        if (w[31:20] == 12'h000) return 17'd2;
        if (w[31:20] == 12'h001) return 17'd1;
        return 17'd4;
      end
      if (f3 == 3'd4) return 17'd4;
      return csr ? {CSR_V, 3'b000} : 17'd4;
    end
    return 17'd4;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out();
    chk("a.valid", {63'd0, ov_a}, {63'd0, m_v[0]});
    chk("a.ctrl", {47'd0, csr_a, src_a, m2r_a, regw_a, mr_a, mw_a, br_a,
                   pcs_a, aop_a, ill_a, ec_a, eb_a}, {47'd0, m_d[0]});
    chk("a.inst", {32'd0, oi_a}, {32'd0, m_i[0]});
    chk("a.pc", op_a, m_p[0]);
    chk("a.halt", {62'd0, hlt_a, hc_a}, {62'd0, m_h[0], m_c[0]});
    chk("a.cnt", {32'd0, cnt_a}, {32'd0, m_n[0]});
    chk("b.valid", {63'd0, ov_b}, {63'd0, m_v[1]});
    chk("b.ctrl", {47'd0, csr_b, src_b, m2r_b, regw_b, mr_b, mw_b, br_b,
                   pcs_b, aop_b, ill_b, ec_b, eb_b}, {47'd0, m_d[1]});
    chk("b.inst", {32'd0, oi_b}, {32'd0, m_i[1]});
    chk("b.pc", op_b, m_p[1]);
    chk("b.halt", {62'd0, hlt_b, hc_b}, {62'd0, m_h[1], m_c[1]});
    chk("b.cnt", {60'd0, cnt_b}, {32'd0, m_n[1]});
  endtask

  task automatic cycle();
    bit rr, er, inf, outf;
    #1;
    if (!rst)
      chk("a.in_ready", {63'd0, rdy_a},
          {63'd0, !m_h[0] && !flush && (!m_v[0] || out_ready)});
    if (!rst2)
      chk("b.in_ready", {63'd0, rdy_b},
          {63'd0, !m_h[1] && !flush && (!m_v[1] || out_ready)});
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      rr   = (d == 0) ? rst : rst2;
      er   = !m_h[d] && !flush && (!m_v[d] || out_ready);
      inf  = in_valid && er;
      outf = m_v[d] && out_ready;
      if (rr) begin
        m_v[d] = 0; m_h[d] = 0; m_c[d] = 0; m_d[d] = '0;
        m_i[d] = '0; m_p[d] = '0; m_n[d] = 0;
      end else begin
        if (outf && !flush) begin
          m_n[d] = (d == 0) ? m_n[d] + 1 : (m_n[d] + 1) % 16;
          if (!m_h[d] && (m_d[d][2] || m_d[d][0])) begin
            m_h[d] = 1;
            m_c[d] = m_d[d][2];
          end
        end
        if (flush) m_v[d] = 0;
        else if (inf) begin
          m_v[d] = 1;
          m_d[d] = ref_dec(in_inst, d == 0, d == 0);
          m_i[d] = in_inst;
          m_p[d] = in_pc;
        end else if (outf) m_v[d] = 0;
      end
    end
    chk_out();
  endtask

  task automatic go(input bit v, input logic [31:0] i, input bit f,
                    input bit r);
    in_valid  = v;
    in_inst   = i;
    flush     = f;
    out_ready = r;
    in_pc     = {$urandom, $urandom};
    cycle();
  endtask

  task automatic reset_both();
    rst = 1; rst2 = 1;
    go(0, 32'h0, 0, 1);
    rst = 0; rst2 = 0;
  endtask

  initial begin
    rst = 1; rst2 = 1; in_valid = 0; flush = 0; out_ready = 1;
    in_inst = '0; in_pc = '0;
    reset_both();
    chk("reset.valid", {63'd0, ov_a}, 64'd0);
    chk("reset.cnt", {32'd0, cnt_a}, 64'd0);

    go(1, 32'h00100093, 0, 1);
    chk("addi.valid", {63'd0, ov_a}, 64'd1);
    go(1, 32'h0000B103, 0, 1);
    go(1, 32'h0020B023, 0, 1);
    go(0, 32'h0, 0, 1);
    chk("stream.cnt", {32'd0, cnt_a}, 64'd3);

    go(1, 32'h008000EF, 0, 0);
    repeat (4) go(1, 32'h00100093, 0, 0);
    chk("bp.pcs", {62'd0, pcs_a}, 64'd1);
    chk("bp.m2r", {61'd0, m2r_a}, 64'd3);
    go(0, 32'h0, 0, 1);
    chk("bp.cnt", {32'd0, cnt_a}, 64'd4);

    go(1, 32'h00100073, 0, 0);
    go(1, 32'h00100093, 1, 1);
    chk("flush.valid", {63'd0, ov_a}, 64'd0);
    chk("flush.cnt", {32'd0, cnt_a}, 64'd4);
    go(0, 32'h0, 0, 1);
    chk("flush.halted", {63'd0, hlt_a}, 64'd0);

    go(1, 32'h00000073, 0, 1);
    go(0, 32'h0, 0, 1);
    chk("ecall.flag", {63'd0, ec_a}, 64'd1);
    chk("ecall.nohalt", {63'd0, hlt_a}, 64'd0);

    go(1, 32'h002081BB, 0, 1);
    chk("addw.aop", {61'd0, aop_a}, 64'd6);
    chk("addw.b_ill", {63'd0, ill_b}, 64'd1);
    go(0, 32'h0, 0, 1);
    chk("addw.b_halt", {62'd0, hlt_b, hc_b}, 64'd3);
    go(0, 32'h0, 0, 1);

    rst2 = 1;
    go(0, 32'h0, 0, 1);
    rst2 = 0;
    go(1, 32'h30571073, 0, 1);
    chk("csr.a_vec", {50'd0, csr_a, src_a, m2r_a, regw_a, mr_a, mw_a, br_a,
                      pcs_a, aop_a}, {50'd0, CSR_V});
    chk("csr.b_ill", {63'd0, ill_b}, 64'd1);
    go(0, 32'h0, 0, 1);
    chk("csr.b_halt", {62'd0, hlt_b, hc_b}, 64'd3);

    go(1, 32'h00100073, 0, 1);
    chk("ebreak.flag", {63'd0, eb_a}, 64'd1);
    go(0, 32'h0, 0, 1);
    chk("ebreak.halt", {62'd0, hlt_a, hc_a}, 64'd2);
    repeat (3) go(1, 32'h00100093, 0, 1);
    chk("ebreak.ready", {63'd0, rdy_a}, 64'd0);

    reset_both();
    repeat (16) go(1, 32'h00100093, 0, 1);
    go(0, 32'h0, 0, 1);
    chk("wrap.b_cnt", {60'd0, cnt_b}, 64'd0);
    chk("wrap.a_cnt", {32'd0, cnt_a}, 64'd16);

    go(1, 32'h0000B103, 0, 0);
    rst = 1; rst2 = 1;
    go(1, 32'h0000B103, 0, 0);
    rst = 0; rst2 = 0;
    chk("rstmid.valid", {63'd0, ov_a}, 64'd0);
    chk("rstmid.mem_r", {63'd0, mr_a}, 64'd0);

    for (int n = 0; n < 600; n++) begin
      logic [31:0] w;
      int k;
      k = $urandom_range(0, 19);
      w = (k >= 17) ? ((k == 19) ? $urandom : pool[k - 17]) : pool[k];
      rst  = m_h[0] || ($urandom_range(0, 63) == 0);
      rst2 = m_h[1] || ($urandom_range(0, 63) == 0);
      go($urandom_range(0, 3) != 0, w, $urandom_range(0, 9) == 0,
         $urandom_range(0, 2) != 0);
    end
    reset_both();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
